// File: rtl/video_pkg.sv
// Shared definitions for the LCD video card text path.
// Control codes, FSM states and VRAM word layout.
package video_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    localparam logic [7:0] ATTR_DEF = 8'h07;

    localparam logic [7:0] CHR_NUL = 8'h00;
    localparam logic [7:0] CHR_BS  = 8'h08;
    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_FF  = 8'h0C;
    localparam logic [7:0] CHR_CR  = 8'h0D;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUT,
        S_CLR_LINE,
        S_CLR_ALL
    } state_t;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_CR,
        CUR_BS,
        CUR_HOME,
        CUR_NEXT,
        CUR_LF
    } cur_cmd_t;

    function automatic logic [ADDR_W-1:0] vram_addr(
        input logic [4:0] row,
        input logic [4:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/text_console_if.sv
// Byte stream handshake into the text console.
// Source drives byte/attribute/valid, console returns ready.
interface text_console_if;

    logic [7:0] chr_i;
    logic [7:0] attr_i;
    logic       chr_valid_i;
    logic       chr_ready_o;

    modport master (
        output chr_i,
        output attr_i,
        output chr_valid_i,
        input  chr_ready_o
    );

    modport slave (
        input  chr_i,
        input  attr_i,
        input  chr_valid_i,
        output chr_ready_o
    );

endinterface

// File: rtl/text_console_cursor.sv
// Cursor position registers for the text console.
// Exposes both the current and the next position.
module console_cursor
    import video_pkg::*;
#(
    parameter int COLS = 30,
    parameter int ROWS = 17
) (
    input  logic     clk_i,
    input  logic     rstn_i,
    input  cur_cmd_t cmd_i,
    output logic [4:0] row_o,
    output logic [4:0] col_o,
    output logic [4:0] row_nxt_o,
    output logic [4:0] col_nxt_o
);

    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic       row_wrap;
    logic [4:0] row_adv;

    assign row_wrap = (row_o == LAST_ROW);
    assign row_adv  = row_wrap ? 5'd0 : row_o + 5'd1;

    // Next cursor position for the requested command.
    always_comb begin
        row_nxt_o = row_o;
        col_nxt_o = col_o;
        unique case (cmd_i)
            CUR_CR: col_nxt_o = 5'd0;
            CUR_BS: begin
                if (col_o != 5'd0) col_nxt_o = col_o - 5'd1;
            end
            CUR_HOME: begin
                row_nxt_o = 5'd0;
                col_nxt_o = 5'd0;
            end
            CUR_NEXT: begin
                if (col_o == LAST_COL) begin
                    col_nxt_o = 5'd0;
                    row_nxt_o = row_adv;
                end else begin
                    col_nxt_o = col_o + 5'd1;
                end
            end
            CUR_LF: row_nxt_o = row_adv;
            default: ;
        endcase
    end

    // Cursor register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            row_o <= 5'd0;
            col_o <= 5'd0;
        end else begin
            row_o <= row_nxt_o;
            col_o <= col_nxt_o;
        end
    end

endmodule

// File: rtl/text_console.sv
// Character-stream front end writing the text VRAM port A.
// Outputs are registered from the next FSM state.
module text_console
    import video_pkg::*;
#(
    parameter int         COLS      = 30,
    parameter int         ROWS      = 17,
    parameter logic [7:0] BLANK_CHR = 8'h20
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    text_console_if.slave       chr_if,
    output logic                vram_cea_o,
    output logic [ADDR_W-1:0]   vram_ada_o,
    output logic [DATA_W-1:0]   vram_din_o,
    output logic [4:0]          cur_row_o,
    output logic [4:0]          cur_col_o,
    output logic                busy_o
);

    localparam logic [4:0] LAST_COL = 5'(COLS - 1);

    state_t      state, state_nxt;
    logic [9:0]  clr_cnt, cnt_nxt;
    logic [7:0]  chr_reg, chr_nxt;
    logic [7:0]  attr_reg, attr_nxt;
    logic        bs_reg, bs_nxt;
    logic        ready_q;
    cur_cmd_t    cmd;
    logic [4:0]  row_nxt, col_nxt;

    logic              cea_n;
    logic [ADDR_W-1:0] ada_n;
    logic [DATA_W-1:0] din_n;

    logic [7:0] in_chr;
    assign in_chr = chr_if.chr_i;

    assign chr_if.chr_ready_o = ready_q;

    console_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .cmd_i     (cmd),
        .row_o     (cur_row_o),
        .col_o     (cur_col_o),
        .row_nxt_o (row_nxt),
        .col_nxt_o (col_nxt)
    );

    // Next-state decode; clear counters only advance once a word is out,
    // so the first cycle after reset emits address 0 before counting.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = clr_cnt;
        chr_nxt   = chr_reg;
        attr_nxt  = attr_reg;
        bs_nxt    = bs_reg;
        cmd       = CUR_NONE;
        unique case (state)
            S_IDLE: begin
                if (chr_if.chr_valid_i) begin
                    unique case (1'b1)
                        (in_chr == CHR_CR): cmd = CUR_CR;
                        (in_chr == CHR_LF): begin
                            cmd       = CUR_LF;
                            cnt_nxt   = 10'd0;
                            state_nxt = S_CLR_LINE;
                        end
                        (in_chr == CHR_BS): begin
                            if (cur_col_o != 5'd0) begin
                                cmd       = CUR_BS;
                                chr_nxt   = BLANK_CHR;
                                bs_nxt    = 1'b1;
                                state_nxt = S_PUT;
                            end
                        end
                        (in_chr == CHR_FF): begin
                            cmd       = CUR_HOME;
                            attr_nxt  = chr_if.attr_i;
                            cnt_nxt   = 10'd0;
                            state_nxt = S_CLR_ALL;
                        end
                        (in_chr == CHR_NUL): ;
                        default: begin
                            chr_nxt   = in_chr;
                            attr_nxt  = chr_if.attr_i;
                            bs_nxt    = 1'b0;
                            state_nxt = S_PUT;
                        end
                    endcase
                end
            end
            S_PUT: begin
                if (bs_reg) begin
                    state_nxt = S_IDLE;
                end else begin
                    cmd = CUR_NEXT;
                    if (cur_col_o == LAST_COL) begin
                        cnt_nxt   = 10'd0;
                        state_nxt = S_CLR_LINE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_CLR_LINE: begin
                if (vram_cea_o) begin
                    if (clr_cnt[4:0] == 5'd31) begin
                        cnt_nxt   = 10'd0;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt = clr_cnt + 10'd1;
                    end
                end
            end
            S_CLR_ALL: begin
                if (vram_cea_o) begin
                    if (clr_cnt == 10'd1023) begin
                        cnt_nxt   = 10'd0;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt = clr_cnt + 10'd1;
                    end
                end
            end
            default: state_nxt = S_CLR_ALL;
        endcase
    end

    // VRAM word for the state being entered.
    always_comb begin
        cea_n = 1'b0;
        ada_n = '0;
        din_n = '0;
        unique case (state_nxt)
            S_PUT: begin
                cea_n = 1'b1;
                ada_n = vram_addr(row_nxt, col_nxt);
                din_n = {attr_nxt, chr_nxt};
            end
            S_CLR_LINE: begin
                cea_n = 1'b1;
                ada_n = vram_addr(row_nxt, cnt_nxt[4:0]);
                din_n = {attr_nxt, BLANK_CHR};
            end
            S_CLR_ALL: begin
                cea_n = 1'b1;
                ada_n = cnt_nxt;
                din_n = {attr_nxt, BLANK_CHR};
            end
            default: ;
        endcase
    end

    // State, latched byte and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= S_CLR_ALL;
            clr_cnt    <= 10'd0;
            chr_reg    <= 8'h00;
            attr_reg   <= ATTR_DEF;
            bs_reg     <= 1'b0;
            ready_q    <= 1'b0;
            busy_o     <= 1'b1;
            vram_cea_o <= 1'b0;
            vram_ada_o <= '0;
            vram_din_o <= '0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= cnt_nxt;
            chr_reg    <= chr_nxt;
            attr_reg   <= attr_nxt;
            bs_reg     <= bs_nxt;
            ready_q    <= (state_nxt == S_IDLE);
            busy_o     <= (state_nxt == S_CLR_LINE) ||
                          (state_nxt == S_CLR_ALL);
            vram_cea_o <= cea_n;
            vram_ada_o <= ada_n;
            vram_din_o <= din_n;
        end
    end

endmodule
